// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unified memory port between instruction fetch (IF) and the
// data stage (DM). Data has priority. Once a transaction is granted and the
// memory stalls it, the owner is locked until mem_ready. Each requester is
// served once per pipeline advance, and its read data is held until both
// requesters are satisfied. mem_stall freezes the pipeline meanwhile.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   if_req/if_addr     fetch request; if_rdata returns the instruction word
//   dm_req/dm_we/...   data request (load/store); dm_rdata returns load data
//   mem_*              unified memory port (mem_ready/mem_rdata are same-cycle)
//   mem_stall          pipeline freeze level for the hazard unit
//   stall_cnt          free-running count of stalled cycles (wraps)
//
// state   | meaning
// IDLE    | no locked owner; grant by priority from pending requests
// LOCK_DM | data access presented, waiting for mem_ready
// LOCK_IF | fetch access presented, waiting for mem_ready
module mem_port_arbiter #(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  // Counter value after reset; nonzero only to exercise wrap in simulation.
  parameter logic [31:0] STALL_CNT_INIT = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_valid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_stall,
  output logic [31:0]         stall_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK_DM = 2'd1,
    LOCK_IF = 2'd2
  } owner_t;

  owner_t            owner;
  logic              served_dm, served_if;
  logic [DATA_W-1:0] dm_rdata_q, if_rdata_q;

  logic pend_dm, pend_if;
  logic gnt_dm, gnt_if;
  logic done_dm, done_if;
  logic sat_dm, sat_if;

  // Grants are suppressed during reset so the port goes quiet immediately.
  always_comb begin
    pend_dm = dm_req & ~served_dm;
    pend_if = if_req & ~served_if;
    gnt_dm  = 1'b0;
    gnt_if  = 1'b0;
    if (!rst) begin
      case (owner)
        LOCK_DM: gnt_dm = 1'b1;
        LOCK_IF: gnt_if = 1'b1;
        default: begin
          if (pend_dm)      gnt_dm = 1'b1;
          else if (pend_if) gnt_if = 1'b1;
        end
      endcase
    end
    done_dm   = gnt_dm & mem_ready;
    done_if   = gnt_if & mem_ready;
    sat_dm    = ~dm_req | served_dm | done_dm;
    sat_if    = ~if_req | served_if | done_if;
    mem_stall = ~rst & ~(sat_dm & sat_if);
  end

  // Fetches never write: we and strobes are forced low on a fetch grant.
  always_comb begin
    mem_valid = gnt_dm | gnt_if;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (gnt_dm) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_wstrb = dm_wstrb;
    end else if (gnt_if) begin
      mem_addr  = if_addr;
    end
  end

  assign dm_rdata = served_dm ? dm_rdata_q : mem_rdata;
  assign if_rdata = served_if ? if_rdata_q : mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= IDLE;
      served_dm  <= 1'b0;
      served_if  <= 1'b0;
      dm_rdata_q <= '0;
      if_rdata_q <= '0;
      stall_cnt  <= STALL_CNT_INIT;
    end else begin
      if (gnt_dm)      owner <= mem_ready ? IDLE : LOCK_DM;
      else if (gnt_if) owner <= mem_ready ? IDLE : LOCK_IF;
      else             owner <= IDLE;

      // Served flags live only until the pipeline advances.
      if (!mem_stall) begin
        served_dm <= 1'b0;
        served_if <= 1'b0;
      end else begin
        if (done_dm) begin
          served_dm  <= 1'b1;
          dm_rdata_q <= mem_rdata;
        end
        if (done_if) begin
          served_if  <= 1'b1;
          if_rdata_q <= mem_rdata;
        end
      end

      if (mem_stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_rdata;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic [31:0] stall_cnt;

  // Second instance with the counter starting at all-ones, for wrap.
  logic [31:0] w_if_rdata, w_dm_rdata, w_mem_addr, w_mem_wdata, w_stall_cnt;
  logic        w_mem_valid, w_mem_we, w_mem_stall;
  logic [3:0]  w_mem_wstrb;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .stall_cnt(stall_cnt)
  );

  mem_port_arbiter #(.STALL_CNT_INIT(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(w_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(w_dm_rdata),
    .mem_valid(w_mem_valid), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_wstrb(w_mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_stall(w_mem_stall), .stall_cnt(w_stall_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0;
    dm_wdata = '0; dm_wstrb = '0; mem_ready = 1'b0; mem_rdata = '0;
  endtask

  // Leaves the caller 1 time unit after the reset edge, reset released.
  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        ready;
    logic [31:0] rdata;
    logic        e_valid;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic        e_stall;
    int          e_rsel;   // 0 none, 1 if_rdata, 2 dm_rdata follows mem_rdata
  } vec_t;

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d0, d1, held, prev_addr, wr_data, wr_addr, rd_addr;
    logic [3:0]  wr_strb;
    int          w, writes, reads, stalls, unstable, order_bad, held_bad;
    bit          have_prev, held_valid, done_loop;

    //                if  ifaddr        dm we dmaddr        wdata          strb  rdy rdata          v  we addr          strb  st rsel
    vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0,        32'h0,         4'h0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0000_0100, 4'h0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_2000, 32'h0,        4'h0, 1'b1, 32'hAABB_CCDD, 1'b1, 1'b0, 32'h0000_2000, 4'h0, 1'b0, 2};
    vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_3000, 32'hCAFE_F00D, 4'h3, 1'b1, 32'h0,        1'b1, 1'b1, 32'h0000_3000, 4'h3, 1'b0, 0};
    vecs[3] = '{1'b1, 32'h0000_0104, 1'b1, 1'b0, 32'h0000_2000, 32'h0,        4'h0, 1'b1, 32'h1234_0001, 1'b1, 1'b0, 32'h0000_2000, 4'h0, 1'b1, 2};
    vecs[4] = '{1'b1, 32'h0000_0104, 1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678, 4'hF, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_2004, 4'hF, 1'b1, 0};
    vecs[5] = '{1'b1, 32'h0000_0108, 1'b0, 1'b0, 32'h0,        32'h0,         4'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0108, 4'h0, 1'b1, 0};
    vecs[6] = '{1'b0, 32'h0000_0108, 1'b0, 1'b0, 32'h0000_2008, 32'h0,        4'h0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         4'h0, 1'b0, 0};
    vecs[7] = '{1'b1, 32'h0000_010C, 1'b0, 1'b1, 32'h0000_200C, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0000_0077, 1'b1, 1'b0, 32'h0000_010C, 4'h0, 1'b0, 1};

    // Reset state
    reset_dut();
    @(negedge clk);
    chk("reset stall_cnt", 64'(stall_cnt), 64'h0);
    chk("reset mem_valid", 64'(mem_valid), 64'h0);
    chk("reset mem_stall", 64'(mem_stall), 64'h0);
    chk("reset owner", 64'(dut.owner), 64'h0);
    chk("reset dm_rdata_q", 64'(dut.dm_rdata_q), 64'h0);
    chk("reset if_rdata_q", 64'(dut.if_rdata_q), 64'h0);
    chk("reset wrap cnt", 64'(w_stall_cnt), 64'hFFFF_FFFF);

    // Wrap: one stall cycle from all-ones
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0300; mem_ready = 1'b0;
    @(negedge clk);
    chk("wrap stall level", 64'(w_mem_stall), 64'h1);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("wrap cnt to zero", 64'(w_stall_cnt), 64'h0);
    chk("main cnt one", 64'(stall_cnt), 64'h1);

    // Single-cycle vectors, each from a fresh IDLE state
    for (int i = 0; i < 8; i++) begin
      reset_dut();
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we; dm_addr = vecs[i].dm_addr;
      dm_wdata = vecs[i].dm_wdata; dm_wstrb = vecs[i].dm_wstrb;
      mem_ready = vecs[i].ready; mem_rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d mem_valid", i), 64'(mem_valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d mem_stall", i), 64'(mem_stall), 64'(vecs[i].e_stall));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d mem_we", i), 64'(mem_we), 64'(vecs[i].e_we));
        chk($sformatf("vec%0d mem_addr", i), 64'(mem_addr), 64'(vecs[i].e_addr));
        chk($sformatf("vec%0d mem_wstrb", i), 64'(mem_wstrb), 64'(vecs[i].e_wstrb));
      end
      if (vecs[i].e_we)
        chk($sformatf("vec%0d mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].dm_wdata));
      if (vecs[i].e_rsel == 1)
        chk($sformatf("vec%0d if_rdata", i), 64'(if_rdata), 64'(vecs[i].rdata));
      if (vecs[i].e_rsel == 2)
        chk($sformatf("vec%0d dm_rdata", i), 64'(dm_rdata), 64'(vecs[i].rdata));
    end

    // Both requesters, zero-wait
    reset_dut();
    d0 = 32'h1111_2222; d1 = 32'h3333_4444;
    dm_req = 1'b1; dm_addr = 32'h0000_2000; if_req = 1'b1; if_addr = 32'h0000_0104;
    mem_ready = 1'b1; mem_rdata = d0;
    @(negedge clk);
    chk("zw c0 addr", 64'(mem_addr), 64'h2000);
    chk("zw c0 stall", 64'(mem_stall), 64'h1);
    @(posedge clk); #1;
    mem_rdata = d1;
    @(negedge clk);
    chk("zw c1 addr", 64'(mem_addr), 64'h0104);
    chk("zw c1 stall", 64'(mem_stall), 64'h0);
    chk("zw c1 dm_rdata", 64'(dm_rdata), 64'(d0));
    chk("zw c1 if_rdata", 64'(if_rdata), 64'(d1));
    chk("zw c1 stall_cnt", 64'(stall_cnt), 64'h1);

    // Store + fetch with 2 wait states per access
    reset_dut();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_4000; dm_wdata = 32'hDEAD_BEEF;
    dm_wstrb = 4'hF; if_req = 1'b1; if_addr = 32'h0000_0110;
    w = 0; writes = 0; reads = 0; stalls = 0; unstable = 0; order_bad = 0; held_bad = 0;
    have_prev = 1'b0; held_valid = 1'b0; done_loop = 1'b0; held = '0; prev_addr = '0;
    wr_data = '0; wr_addr = '0; wr_strb = '0; rd_addr = '0;
    for (int c = 0; c < 20 && !done_loop; c++) begin
      mem_ready = mem_valid && (w == 2);
      mem_rdata = 32'hA5A5_0000 + 32'(c);
      @(negedge clk);
      if (have_prev && mem_valid && mem_addr !== prev_addr) unstable++;
      if (held_valid && dm_rdata !== held) held_bad++;
      if (mem_stall) stalls++;
      if (mem_valid && mem_ready) begin
        if (mem_we) begin
          writes++;
          if (reads != 0) order_bad++;
          wr_data = mem_wdata; wr_strb = mem_wstrb; wr_addr = mem_addr;
          held = mem_rdata; held_valid = 1'b1;
        end else begin
          reads++;
          rd_addr = mem_addr;
        end
        w = 0;
      end else if (mem_valid) begin
        w++;
      end
      have_prev = mem_valid && !mem_ready;
      prev_addr = mem_addr;
      if (!mem_stall) done_loop = 1'b1;
      @(posedge clk); #1;
    end
    chk("ws advance reached", 64'(done_loop), 64'h1);
    chk("ws writes", 64'(writes), 64'h1);
    chk("ws reads", 64'(reads), 64'h1);
    chk("ws write first", 64'(order_bad), 64'h0);
    chk("ws stall cycles", 64'(stalls), 64'h5);
    chk("ws addr stable", 64'(unstable), 64'h0);
    chk("ws held dm_rdata", 64'(held_bad), 64'h0);
    chk("ws wdata", 64'(wr_data), 64'hDEAD_BEEF);
    chk("ws wstrb", 64'(wr_strb), 64'hF);
    chk("ws waddr", 64'(wr_addr), 64'h4000);
    chk("ws raddr", 64'(rd_addr), 64'h0110);
    chk("ws stall_cnt", 64'(stall_cnt), 64'h5);

    // Fetch locked when data request rises
    reset_dut();
    if_req = 1'b1; if_addr = 32'h0000_0200; mem_ready = 1'b0;
    @(negedge clk);
    chk("lif c0 addr", 64'(mem_addr), 64'h0200);
    @(posedge clk); #1;
    dm_req = 1'b1; dm_addr = 32'h0000_2400;
    @(negedge clk);
    chk("lif c1 owner", 64'(dut.owner), 64'h2);
    chk("lif c1 addr", 64'(mem_addr), 64'h0200);
    chk("lif c1 we", 64'(mem_we), 64'h0);
    chk("lif c1 stall", 64'(mem_stall), 64'h1);
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_rdata = 32'h0000_0A01;
    @(negedge clk);
    chk("lif c2 addr", 64'(mem_addr), 64'h0200);
    chk("lif c2 stall", 64'(mem_stall), 64'h1);
    @(posedge clk); #1;
    mem_rdata = 32'h0000_0B02;
    @(negedge clk);
    chk("lif c3 addr", 64'(mem_addr), 64'h2400);
    chk("lif c3 stall", 64'(mem_stall), 64'h0);
    chk("lif c3 if_rdata", 64'(if_rdata), 64'h0A01);
    chk("lif c3 dm_rdata", 64'(dm_rdata), 64'h0B02);
    chk("lif c3 stall_cnt", 64'(stall_cnt), 64'h3);

    // Reset while in LOCK_DM
    reset_dut();
    dm_req = 1'b1; dm_addr = 32'h0000_2800; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdm owner locked", 64'(dut.owner), 64'h1);
    chk("rdm addr", 64'(mem_addr), 64'h2800);
    #1 rst = 1'b1;
    #1;
    chk("rdm in-reset valid", 64'(mem_valid), 64'h0);
    chk("rdm in-reset stall", 64'(mem_stall), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    chk("rdm post valid", 64'(mem_valid), 64'h0);
    chk("rdm post stall", 64'(mem_stall), 64'h0);
    chk("rdm post owner", 64'(dut.owner), 64'h0);
    chk("rdm post served", 64'({dut.served_dm, dut.served_if}), 64'h0);

    // Reset with a served flag set
    reset_dut();
    dm_req = 1'b1; dm_addr = 32'h0000_2C00; if_req = 1'b1; if_addr = 32'h0000_0400;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rsv served_dm set", 64'(dut.served_dm), 64'h1);
    chk("rsv fetch addr", 64'(mem_addr), 64'h0400);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rsv in-reset valid", 64'(mem_valid), 64'h0);
    chk("rsv in-reset stall", 64'(mem_stall), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0; dm_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("rsv served cleared", 64'({dut.served_dm, dut.served_if}), 64'h0);
    chk("rsv owner idle", 64'(dut.owner), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the IF stage (instruction fetch) and the MEM stage (loads and stores). Data requests take priority over fetch. A served requester's read data is held until both requesters are satisfied. The block produces the `MemStall` level consumed by the hazard unit, which freezes F/D/E/M while any active request is still outstanding.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; `DATA_W/8` byte strobes.

Ports:
- `clk`, in, 1: sole clock; all state is updated on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `if_req`, in, 1: fetch request; held stable while `mem_stall`=1.
- `if_addr`, in, `ADDR_W`: fetch address.
- `if_rdata`, out, `DATA_W`: instruction word; valid when `if_req`=1 and `mem_stall`=0.
- `dm_req`, in, 1: data request; held stable while `mem_stall`=1.
- `dm_we`, in, 1: 1 selects store, 0 selects load.
- `dm_addr`, in, `ADDR_W`: data address.
- `dm_wdata`, in, `DATA_W`: store data.
- `dm_wstrb`, in, `DATA_W/8`: byte enables for stores.
- `dm_rdata`, out, `DATA_W`: load data; valid when `dm_req`=1 and `mem_stall`=0.
- `mem_valid`, out, 1: transaction presented on the memory port.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, `ADDR_W`: memory address.
- `mem_wdata`, out, `DATA_W`: memory write data.
- `mem_wstrb`, out, `DATA_W/8`: memory byte enables.
- `mem_ready`, in, 1: memory completes the presented transaction this cycle; `mem_rdata` is valid in the same cycle.
- `mem_rdata`, in, `DATA_W`: memory read data.
- `mem_stall`, out, 1: drives `MemStall` of the hazard unit.
- `stall_cnt`, out, 32: count of cycles with `mem_stall`=1; wraps modulo 2^32.

## Operation
- State machine `owner` has three states: IDLE, LOCK_DM, LOCK_IF. The block also keeps flags `served_dm` and `served_if`, holding registers `dm_rdata_q` and `if_rdata_q`, and `stall_cnt`.
- Pending conditions:
  - `pend_dm` = `dm_req` & ~`served_dm`.
  - `pend_if` = `if_req` & ~`served_if`.
- Grant (combinational):
  - LOCK_DM grants data.
  - LOCK_IF grants fetch.
  - IDLE grants data if `pend_dm`, else fetch if `pend_if`, else nothing.
- `mem_valid` = 1 whenever a grant exists. `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` come from the granted requester. A fetch grant forces `mem_we`=0 and `mem_wstrb`=0.
- Completion: `done_dm` = data granted & `mem_ready`; `done_if` = fetch granted & `mem_ready`.
- Satisfaction: `sat_dm` = ~`dm_req` | `served_dm` | `done_dm`; `sat_if` is the same for fetch.
- `mem_stall` = ~(`sat_dm` & `sat_if`). This is combinational from `mem_ready`.
- Read data muxing:
  - `dm_rdata` = `served_dm` ? `dm_rdata_q` : `mem_rdata`.
  - `if_rdata` = `served_if` ? `if_rdata_q` : `mem_rdata`.
- State transitions:
  - Granted with no `mem_ready`: `owner` goes to the lock for that requester.
  - Granted with `mem_ready`: `owner` goes to IDLE.
  - Nothing granted: `owner` stays IDLE.
- Flag updates:
  - If `mem_stall`=0 (pipeline advances): clear both served flags.
  - Else if `done_dm`: set `served_dm` and capture `mem_rdata` into `dm_rdata_q`.
  - `done_if` updates `served_if` and `if_rdata_q` the same way.
- Once locked, the owner is never switched away before `mem_ready`. `mem_valid` and the payload stay stable until completion.
- Each requester gets exactly one memory transaction per pipeline advance. Stores are never re-issued.
- `stall_cnt` increments every cycle in which `mem_stall`=1.

## Timing
- Zero-wait memory (`mem_ready` held at 1):
  - Single requester: 0 stall cycles.
  - Both requesters: 1 stall cycle. Data completes in cycle t, fetch in cycle t+1, and the advance happens at t+1.
- With N wait states per access, both requesters cost 2(N+1)-1 stall cycles.
- A grant from IDLE presents on the port in the same cycle; there is no added latency.
- Held data is returned from `*_rdata_q` in every cycle after its capture, until the advance.
- Reset values:
  - `owner`=IDLE.
  - Served flags = 0.
  - Holding registers = 0.
  - `stall_cnt`=0.
- While `rst`=1, `mem_valid`=0 and `mem_stall`=0 regardless of inputs.
- Reset mid-transaction abandons the access. The memory must tolerate `mem_valid` dropping.
- A request dropped while unserved is an illegal pipeline behaviour and is not checked.
- When `stall_cnt` reaches 0xFFFFFFFF, it wraps to 0 on the next stall cycle.

## Test plan
- `dm_req`=0, `if_req`=1, `if_addr`=0x100, `mem_ready`=1 -> `mem_valid`=1, `mem_addr`=0x100, `mem_stall`=0, `if_rdata`=`mem_rdata`.
- Load at 0x2000 and fetch at 0x104 in the same cycle, `mem_ready`=1 -> cycle 0: port shows 0x2000 and `mem_stall`=1. Cycle 1: port shows 0x104, `mem_stall`=0, `dm_rdata` equals the cycle-0 data, `stall_cnt`=1.
- Store 0xDEADBEEF, `wstrb`=0xF, with fetch, and the memory inserts 2 wait states on each access -> exactly one write is observed, then one read. `mem_stall` is high for 5 cycles, and the address is stable throughout each lock.
- `owner` is LOCK_IF (fetch waiting) when `dm_req` rises -> fetch completes first and data is issued afterwards; there is no switch while locked.
- `rst` asserted while in LOCK_DM -> the next cycle shows `mem_valid`=0, `mem_stall`=0, `owner`=IDLE, and served flags cleared.
- `stall_cnt` preloaded to 0xFFFFFFFF through the bench, then one stall cycle -> `stall_cnt`=0.
